// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 transaction arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ats21_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int ATS_CTRL_W = 16;
  localparam int ATS_DATA_W = 24;
  localparam int ATS_STAT_W = 2;

  // Reported when the engine never raises ready; a real 2'b11 looks the same.
  localparam logic [ATS_STAT_W-1:0] STAT_TIMEOUT = 2'b11;

  // Round-robin successor of a client index.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/ats21_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, searching upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk the request vector starting at ptr; keep only the first hit.
  always_comb begin
    any  = 1'b0;
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ats21_arbiter.sv
// Shares one ATS21 engine between NREQ clients with round-robin grants and a watchdog.
// Latency: grant at edge k gives ats_req in cycle k+1; ready at end of m gives rsp_valid in m+1.
// Backpressure: response held stable until rsp_ready; no new grant until the handshake completes.
module ats21_arbiter
  import ats21_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            cli_req,
  input  logic [NREQ*ATS_CTRL_W-1:0] cli_ctrlA,
  input  logic [NREQ*ATS_CTRL_W-1:0] cli_ctrlB,
  output logic [NREQ-1:0]            cli_ack,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [ATS_STAT_W-1:0]      rsp_stat,
  output logic [ATS_DATA_W-1:0]      rsp_data,
  output logic                       ats_req,
  output logic [ATS_CTRL_W-1:0]      ats_ctrlA,
  output logic [ATS_CTRL_W-1:0]      ats_ctrlB,
  input  logic                       ats_ready,
  input  logic [ATS_STAT_W-1:0]      ats_stat,
  input  logic [ATS_DATA_W-1:0]      ats_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_e          state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;

  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;

  logic [ATS_CTRL_W-1:0] ctl_a [NREQ];
  logic [ATS_CTRL_W-1:0] ctl_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ctl_a[g] = cli_ctrlA[g*ATS_CTRL_W +: ATS_CTRL_W];
    assign ctl_b[g] = cli_ctrlB[g*ATS_CTRL_W +: ATS_CTRL_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (cli_req),
    .ptr (rr_ptr),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Transaction FSM: grant in IDLE, hold the ATS21 request in BUSY, present the response in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      cli_ack   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_stat  <= '0;
      rsp_data  <= '0;
      ats_req   <= 1'b0;
      ats_ctrlA <= '0;
      ats_ctrlB <= '0;
    end else begin
      cli_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            rr_ptr    <= IW'(next_idx(int'(pick_idx), NREQ));
            rsp_id    <= pick_idx;
            cli_ack   <= pick_gnt;
            cnt       <= '0;
            ats_req   <= 1'b1;
            ats_ctrlA <= ctl_a[pick_idx];
            ats_ctrlB <= ctl_b[pick_idx];
          end
        end
        BUSY: begin
          // A ready on the watchdog edge still returns the engine's real result.
          if (ats_ready) begin
            state     <= RESP;
            ats_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_stat  <= ats_stat;
            rsp_data  <= ats_data;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            ats_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_stat  <= STAT_TIMEOUT;
            rsp_data  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_arbiter.sv
// Randomized bench for ats21_arbiter against a transaction-level reference model.
// Latency: checks grant, busy window, response timing per transaction.
// Backpressure: random rsp_ready holds with stability checks.
module tb_ats21_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      cli_req;
  logic [NREQ*16-1:0]   cli_ctrlA;
  logic [NREQ*16-1:0]   cli_ctrlB;
  logic [NREQ-1:0]      cli_ack;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [1:0]           rsp_stat;
  logic [23:0]          rsp_data;
  logic                 ats_req;
  logic [15:0]          ats_ctrlA;
  logic [15:0]          ats_ctrlB;
  logic                 ats_ready;
  logic [1:0]           ats_stat;
  logic [23:0]          ats_data;

  always #5 clk = ~clk;

  ats21_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cli_req   (cli_req),
    .cli_ctrlA (cli_ctrlA),
    .cli_ctrlB (cli_ctrlB),
    .cli_ack   (cli_ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_stat  (rsp_stat),
    .rsp_data  (rsp_data),
    .ats_req   (ats_req),
    .ats_ctrlA (ats_ctrlA),
    .ats_ctrlB (ats_ctrlB),
    .ats_ready (ats_ready),
    .ats_stat  (ats_stat),
    .ats_data  (ats_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending clients, their control words, round-robin pointer.
  logic [NREQ-1:0] pend;
  logic [15:0]     ca [NREQ];
  logic [15:0]     cb [NREQ];
  int              ptr;
  int              last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_clients();
    cli_ctrlA = {ca[3], ca[2], ca[1], ca[0]};
    cli_ctrlB = {cb[3], cb[2], cb[1], cb[0]};
    cli_req   = pend;
  endtask

  task automatic add_req(input int c);
    if (!pend[c]) begin
      pend[c] = 1'b1;
      ca[c]   = 16'($urandom);
      cb[c]   = 16'($urandom);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},  32'(ats_req), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ack"},  32'(cli_ack), 32'd0);
  endtask

  // One transaction, entered at the falling edge of an IDLE cycle with pend != 0.
  // lat: busy cycle (1-based) whose closing edge sees ats_ready; > TIMEOUT means never.
  task automatic run_txn(input int lat, input int hold, input logic [1:0] st, input logic [23:0] dt);
    int          g;
    int          b;
    bit          done;
    logic [1:0]  es;
    logic [23:0] ed;
    g      = pick();
    ptr    = (g + 1) % NREQ;
    last_g = g;
    es     = 2'b00;
    ed     = 24'd0;
    rsp_ready = 1'b0;
    ats_ready = 1'b0;
    drive_clients();
    @(negedge clk);
    b    = 1;
    done = 1'b0;
    while (!done) begin
      chk("busy_req",   32'(ats_req), 32'd1);
      chk("busy_ctrlA", 32'(ats_ctrlA), 32'(ca[g]));
      chk("busy_ctrlB", 32'(ats_ctrlB), 32'(cb[g]));
      chk("busy_rspv",  32'(rsp_valid), 32'd0);
      chk("busy_ack",   32'(cli_ack), (b == 1) ? (32'd1 << g) : 32'd0);
      if (b == 1) begin
        pend[g] = 1'b0;
        cli_req = pend;
      end
      ats_stat = 2'($urandom);
      ats_data = 24'($urandom);
      if (b == lat) begin
        ats_ready = 1'b1;
        ats_stat  = st;
        ats_data  = dt;
        es        = st;
        ed        = dt;
        done      = 1'b1;
      end else begin
        ats_ready = 1'b0;
        if (b == TIMEOUT) begin
          es   = 2'b11;
          ed   = 24'd0;
          done = 1'b1;
        end
      end
      @(negedge clk);
      b++;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_req",   32'(ats_req), 32'd0);
      chk("resp_ack",   32'(cli_ack), 32'd0);
      chk("resp_id",    32'(rsp_id), 32'(g));
      chk("resp_stat",  32'(rsp_stat), 32'(es));
      chk("resp_data",  32'(rsp_data), 32'(ed));
      rsp_ready = (h == hold);
      ats_ready = 1'($urandom);
      ats_stat  = 2'($urandom);
      ats_data  = 24'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    ats_ready = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    reset     = 1'b0;
    pend      = '0;
    ptr       = 0;
    last_g    = 0;
    rsp_ready = 1'b0;
    ats_ready = 1'b0;
    ats_stat  = '0;
    ats_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      ca[i] = '0;
      cb[i] = '0;
    end
    drive_clients();
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(cli_ack), 32'd0);
    chk("rst_rspv",  32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id), 32'd0);
    chk("rst_stat",  32'(rsp_stat), 32'd0);
    chk("rst_data",  32'(rsp_data), 32'd0);
    chk("rst_req",   32'(ats_req), 32'd0);
    chk("rst_ctrlA", 32'(ats_ctrlA), 32'd0);
    chk("rst_ctrlB", 32'(ats_ctrlB), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("idle0");

    // All clients requesting continuously: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < NREQ; c++) add_req(c);
      run_txn(int'($urandom_range(1, 3)), 0, 2'($urandom), 24'($urandom));
      chk("rr_order", 32'(last_g), 32'(k % NREQ));
    end
    while (pend != '0) run_txn(2, 0, 2'($urandom), 24'($urandom));

    // Single client 2, ready in the third busy cycle.
    add_req(2);
    run_txn(3, 0, 2'b01, 24'hABCDEF);

    // Consumer stalls for 5 cycles.
    add_req(int'($urandom_range(0, NREQ - 1)));
    run_txn(2, 5, 2'b10, 24'h5A5A5A);

    // Engine never ready: watchdog fires, then a normal transaction.
    add_req(1);
    run_txn(TIMEOUT + 3, 0, 2'b01, 24'h111111);
    add_req(0);
    run_txn(2, 0, 2'b00, 24'h222222);

    // Ready exactly on the watchdog edge.
    add_req(3);
    run_txn(TIMEOUT, 0, 2'b10, 24'h123456);

    // Reset in the middle of BUSY drops everything at once.
    add_req(0);
    drive_clients();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req",   32'(ats_req), 32'd0);
    chk("mid_rst_ack",   32'(cli_ack), 32'd0);
    chk("mid_rst_rspv",  32'(rsp_valid), 32'd0);
    chk("mid_rst_ctrlA", 32'(ats_ctrlA), 32'd0);
    @(negedge clk);
    pend = '0;
    drive_clients();
    ptr   = 0;
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    add_req(1);
    add_req(3);
    run_txn(2, 0, 2'($urandom), 24'($urandom));
    chk("post_rst_first", 32'(last_g), 32'd1);
    run_txn(1, 0, 2'($urandom), 24'($urandom));
    chk("post_rst_second", 32'(last_g), 32'd3);

    // Randomized traffic.
    repeat (150) begin
      int lat;
      for (int c = 0; c < NREQ; c++) begin
        if ($urandom_range(0, 2) == 0) add_req(c);
      end
      if (pend == '0) begin
        drive_clients();
        @(negedge clk);
        chk_idle("idle_gap");
        add_req(int'($urandom_range(0, NREQ - 1)));
      end
      lat = int'($urandom_range(1, TIMEOUT + 2));
      if ($urandom_range(0, 4) == 0) lat = TIMEOUT;
      run_txn(lat, int'($urandom_range(0, 3)), 2'($urandom), 24'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ats21_arbiter.md
# ats21_arbiter

Shares one ATS21 transaction engine between NREQ client ports. Round-robin arbitration picks one client, drives the ATS21 req/ctrlA/ctrlB handshake, and waits for ready. It then captures stat/data and returns them to the granted client on a valid/ready response channel. A watchdog aborts transactions that never complete.

## Interface

Parameters:
- NREQ, 4: number of client ports (2..8)
- TIMEOUT, 64: max BUSY cycles before abort (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- cli_req  in  NREQ  per-client request level; held until matching cli_ack
- cli_ctrlA  in  NREQ*16  client i ctrlA at bits [16i+15:16i]
- cli_ctrlB  in  NREQ*16  client i ctrlB, same packing
- cli_ack  out  NREQ  one-cycle one-hot accept pulse
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NREQ)  granted client index
- rsp_stat  out  2  ATS21 stat, or 2'b11 on timeout
- rsp_data  out  24  ATS21 data, or 0 on timeout
- ats_req  out  1  to ATS21 req
- ats_ctrlA  out  16  to ATS21 ctrlA
- ats_ctrlB  out  16  to ATS21 ctrlB
- ats_ready  in  1  from ATS21 ready; stat/data valid while high
- ats_stat  in  2  from ATS21 stat
- ats_data  in  24  from ATS21 data

## Operation

- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE: at an edge where any cli_req is high:
  - Grant the first requester at or after rr_ptr, searching upward with wrap.
  - Latch its index and ctrlA/ctrlB.
  - Set rr_ptr = (grant+1) mod NREQ.
  - Go to BUSY.
  - No request: stay in IDLE; rr_ptr is unchanged.
- BUSY:
  - ats_req=1 and ats_ctrlA/B drive the latched values, stable for the whole state.
  - cli_ack[grant]=1 in the first BUSY cycle only.
  - Timeout counter is cleared on entry and increments each BUSY cycle.
- BUSY exits:
  - ats_ready=1 at an edge: latch ats_stat/ats_data and go to RESP.
  - Else, counter==TIMEOUT-1 at an edge: go to RESP with stat 2'b11 and data 0.
  - ats_ready and timeout on the same edge: ready wins.
- RESP:
  - ats_req=0; rsp_valid=1 with rsp_id/rsp_stat/rsp_data held stable.
  - At an edge with rsp_ready=1, go to IDLE.
- ats_ready while in IDLE or RESP is ignored.
- The granted client is not re-sampled until the FSM is back in IDLE.
- ATS21 stat code 2'b11 passes through unchanged and is indistinguishable from timeout by design.

## Timing

- Reset (async assert, sync release):
  - State IDLE, rr_ptr=0, counter=0.
  - cli_ack=0, rsp_valid=0, rsp_id=0, rsp_stat=0, rsp_data=0.
  - ats_req=0, ats_ctrlA=0, ats_ctrlB=0.
- Request sampled at edge k: BUSY, ats_req and cli_ack are high in cycle k+1.
- ats_ready high in cycle m, sampled at the end of m: rsp_valid high from cycle m+1.
- Best-case turnaround:
  - RESP lasts one cycle if rsp_ready=1.
  - Next grant is sampled at the end of the following IDLE cycle.
  - Maximum issue rate is one transaction per 3+ATS21-latency cycles.
- Timeout: with no ready, rsp_valid rises TIMEOUT cycles after ats_req rose.
- Reset mid-BUSY or mid-RESP drops ats_req/rsp_valid immediately. The transaction is lost and no response is generated.

## Structure

- Shared package ats21_pkg:
  - state enum {IDLE, BUSY, RESP}
  - ATS_CTRL_W=16, ATS_DATA_W=24, ATS_STAT_W=2
  - STAT_TIMEOUT=2'b11
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: NREQ-bit request vector, rr_ptr.
  - Outputs: any, one-hot grant, grant index.

## Test plan

- Single client 2, ATS21 ready 3 cycles after req, stat 2'b01, data 24'hABCDEF -> cli_ack[2] pulses once; ats_ctrlA/B equal client 2's values; rsp_id=2, rsp_stat=2'b01, rsp_data=24'hABCDEF.
- All 4 clients request continuously with rsp_ready=1 -> grant order 0,1,2,3,0; each cli_ack is a single cycle.
- rsp_ready held 0 for 5 cycles -> rsp_valid and fields stable for 5 cycles; no new ats_req until the handshake completes.
- TIMEOUT=8, ATS21 never ready -> ats_req high exactly 8 cycles, then rsp_stat=2'b11 and rsp_data=0; next request is serviced normally.
- ats_ready asserted exactly on the timeout edge -> real stat/data returned, not 2'b11.
- Reset asserted mid-BUSY -> all outputs 0 asynchronously; after release, requests from clients 1 and 3 are granted 1 first (rr_ptr=0).
